// File: rtl/prefix_accumulator.sv
// Purpose : frame accumulator wrapped around the 8-bit prefix_adder; emits frame total + sticky carry every COUNT_N bytes.
// Latency : updated sum/count visible one cycle after accept; total valid one cycle after the last accept of a frame.
// Backpressure: in_ready low while a total is held (HOLD) or clear is high; total held stable until out_ready. Optional macro: SATURATE_EN.

// Kogge-Stone 8-bit adder; operands and result use bit 0 = MSB ordering.
module prefix_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);

    logic [7:0] al, bl, g0, p0, g1, p1, g2, p2, g3, p3, c, sl;

    // One prefix level: combine each (g,p) with the pair d positions below it.
    function automatic logic [15:0] ks_level(input logic [7:0] g, input logic [7:0] p, input int d);
        logic [7:0] go, po;
        for (int i = 0; i < 8; i++) begin
            if (i >= d) begin
                go[i] = g[i] | (p[i] & g[i-d]);
                po[i] = p[i] & p[i-d];
            end else begin
                go[i] = g[i];
                po[i] = p[i];
            end
        end
        return {go, po};
    endfunction

    // Reorder to LSB-first, run the prefix tree, and reorder the sum back.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            al[i] = a[7-i];
            bl[i] = b[7-i];
        end
        g0 = al & bl;
        p0 = al ^ bl;
        {g1, p1} = ks_level(g0, p0, 1);
        {g2, p2} = ks_level(g1, p1, 2);
        {g3, p3} = ks_level(g2, p2, 4);
        c = {g3[6:0], 1'b0};
        sl = p0 ^ c;
        for (int i = 0; i < 8; i++) begin
            sum[7-i] = sl[i];
        end
    end

endmodule

module prefix_accumulator #(
    parameter int WIDTH   = 8,
    parameter int COUNT_N = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);

    // The adder has fixed 8-bit operands; frame length must fit the counter.
    if (WIDTH != 8) begin : g_bad_width
        $error("prefix_accumulator: WIDTH must be 8");
    end
    if (COUNT_N < 1 || COUNT_N > 255) begin : g_bad_count
        $error("prefix_accumulator: COUNT_N must be 1..255");
    end
    if (CNT_W < 1 || CNT_W > 31 || COUNT_N > (2**CNT_W) - 1) begin : g_bad_cnt_w
        $error("prefix_accumulator: CNT_W cannot hold COUNT_N");
    end

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT_N - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, add_sum, add_res;
    logic             carry, carry_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             accept, wrap;

    // Bit 0 is the MSB on the wire; flip to numeric order for magnitude compares.
    function automatic logic [7:0] to_num(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    prefix_adder u_adder (
        .a   (acc),
        .b   (in_data),
        .sum (add_sum)
    );

    assign in_ready  = (state == ST_ACC) && !clear;
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign out_sum   = acc;
    assign out_carry = carry;
    assign out_count = count;

    // A wrap past 0xFF shows up as the sum dropping below the running total.
    always_comb begin
        wrap = (to_num(add_sum) < to_num(acc));
`ifdef SATURATE_EN
        add_res = wrap ? '1 : add_sum;
`else
        add_res = add_sum;
`endif
    end

    // Next-state: clear wins, then accumulate in ACC or release in HOLD.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        carry_nxt = carry;
        count_nxt = count;
        if (clear) begin
            state_nxt = ST_ACC;
            acc_nxt   = '0;
            carry_nxt = 1'b0;
            count_nxt = '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc_nxt   = add_res;
                        carry_nxt = carry | wrap;
                        count_nxt = count + CNT_W'(1);
                        if (count == LAST_IDX) begin
                            state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_nxt = ST_ACC;
                        acc_nxt   = '0;
                        carry_nxt = 1'b0;
                        count_nxt = '0;
                    end
                end
                default: state_nxt = ST_ACC;
            endcase
        end
    end

    // State and datapath registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            carry <= carry_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_prefix_accumulator.sv
// Purpose : directed self-checking bench; instance 0 has COUNT_N=2, instance 1 has COUNT_N=4.
// Latency : outputs sampled on the falling edge, inputs changed 1 time unit after the rising edge.
// Backpressure: exercised by holding out_ready low with in_valid high while a total is held.
module tb_prefix_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear     [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_data   [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_sum   [2];
    logic       out_carry [2];
    logic [7:0] out_count [2];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prefix_accumulator #(.WIDTH(8), .COUNT_N(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_carry(out_carry[0]), .out_count(out_count[0])
    );

    prefix_accumulator #(.WIDTH(8), .COUNT_N(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_carry(out_carry[1]), .out_count(out_count[1])
    );

    // Wire order is bit 0 = MSB.
    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic send(input int idx, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid[idx] = 1'b1;
        in_data[idx]  = rev8(b);
        while (!in_ready[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (in_ready[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL send_timeout idx=%0d byte=%h in_ready=%b required 1", idx, b, in_ready[idx]);
        end
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        in_data[idx]  = 8'hxx;
    endtask

    task automatic handshake(input int idx);
        @(negedge clk);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (out_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid idx=%0d got=%b exp=0", i, out_valid[i]); end
            n_cmp++; if (in_ready[i] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready idx=%0d got=%b exp=1", i, in_ready[i]); end
            n_cmp++; if (out_sum[i] !== 8'h00) begin n_fail++; $display("FAIL reset_out_sum idx=%0d got=%h exp=00", i, out_sum[i]); end
            n_cmp++; if (out_carry[i] !== 1'b0) begin n_fail++; $display("FAIL reset_out_carry idx=%0d got=%b exp=0", i, out_carry[i]); end
            n_cmp++; if (out_count[i] !== 8'd0) begin n_fail++; $display("FAIL reset_out_count idx=%0d got=%0d exp=0", i, out_count[i]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        send(0, 8'h00);
        @(negedge clk);
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_mid_valid got=%b exp=0", out_valid[0]); end
        n_cmp++; if (out_count[0] !== 8'd1) begin n_fail++; $display("FAIL basic_mid_count got=%0d exp=1", out_count[0]); end
        send(0, 8'h41);
        @(negedge clk);
        n_cmp++; if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", out_valid[0]); end
        n_cmp++; if (out_sum[0] !== rev8(8'h41)) begin n_fail++; $display("FAIL basic_sum got=%h exp=%h", rev8(out_sum[0]), 8'h41); end
        n_cmp++; if (out_carry[0] !== 1'b0) begin n_fail++; $display("FAIL basic_carry got=%b exp=0", out_carry[0]); end
        n_cmp++; if (out_count[0] !== 8'd2) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", out_count[0]); end
        handshake(0);
    endtask

    task automatic test_back_to_back;
        send(0, 8'h64);
        send(0, 8'h18);
        @(negedge clk);
        n_cmp++; if (out_sum[0] !== rev8(8'h7C)) begin n_fail++; $display("FAIL b2b_sum1 got=%h exp=7c", rev8(out_sum[0])); end
        n_cmp++; if (out_carry[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_carry1 got=%b exp=0", out_carry[0]); end
        handshake(0);
        @(negedge clk);
        n_cmp++; if (out_sum[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_restart_sum got=%h exp=00", rev8(out_sum[0])); end
        send(0, 8'h55);
        send(0, 8'hAA);
        @(negedge clk);
        n_cmp++; if (out_sum[0] !== 8'hFF) begin n_fail++; $display("FAIL b2b_sum2 got=%h exp=ff", rev8(out_sum[0])); end
        n_cmp++; if (out_carry[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_carry2 got=%b exp=0", out_carry[0]); end
        handshake(0);
    endtask

    task automatic test_carry;
        logic [7:0] exp_sum;
`ifdef SATURATE_EN
        exp_sum = 8'hFF;
`else
        exp_sum = 8'h03;
`endif
        send(1, 8'h80);
        send(1, 8'h80);
        @(negedge clk);
        n_cmp++; if (out_carry[1] !== 1'b1) begin n_fail++; $display("FAIL carry_mid got=%b exp=1", out_carry[1]); end
        send(1, 8'h01);
        send(1, 8'h02);
        @(negedge clk);
        n_cmp++; if (out_valid[1] !== 1'b1) begin n_fail++; $display("FAIL carry_valid got=%b exp=1", out_valid[1]); end
        n_cmp++; if (out_sum[1] !== rev8(exp_sum)) begin n_fail++; $display("FAIL carry_sum got=%h exp=%h", rev8(out_sum[1]), exp_sum); end
        n_cmp++; if (out_carry[1] !== 1'b1) begin n_fail++; $display("FAIL carry_flag got=%b exp=1", out_carry[1]); end
        n_cmp++; if (out_count[1] !== 8'd4) begin n_fail++; $display("FAIL carry_count got=%0d exp=4", out_count[1]); end
        handshake(1);
        @(negedge clk);
        n_cmp++; if (out_carry[1] !== 1'b0) begin n_fail++; $display("FAIL carry_cleared got=%b exp=0", out_carry[1]); end
    endtask

    task automatic test_backpressure;
        send(0, 8'h11);
        send(0, 8'h22);
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = rev8(8'h99);
        out_ready[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready[0]); end
            n_cmp++; if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, out_valid[0]); end
            n_cmp++; if (out_sum[0] !== rev8(8'h33)) begin n_fail++; $display("FAIL bp_sum cyc=%0d got=%h exp=33", c, rev8(out_sum[0])); end
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        in_data[0]   = 8'hxx;
        @(negedge clk);
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_after_valid got=%b exp=0", out_valid[0]); end
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_after_ready got=%b exp=1", in_ready[0]); end
        n_cmp++; if (out_count[0] !== 8'd0) begin n_fail++; $display("FAIL bp_after_count got=%0d exp=0", out_count[0]); end
        n_cmp++; if (out_sum[0] !== 8'h00) begin n_fail++; $display("FAIL bp_after_sum got=%h exp=00", rev8(out_sum[0])); end
    endtask

    task automatic test_clear;
        send(1, 8'h10);
        send(1, 8'h20);
        @(negedge clk);
        n_cmp++; if (out_sum[1] !== rev8(8'h30)) begin n_fail++; $display("FAIL clr_pre_sum got=%h exp=30", rev8(out_sum[1])); end
        clear[1]    = 1'b1;
        in_valid[1] = 1'b1;
        in_data[1]  = rev8(8'h77);
        #1;
        n_cmp++; if (in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready got=%b exp=0", in_ready[1]); end
        @(posedge clk);
        #1;
        clear[1]    = 1'b0;
        in_valid[1] = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_count[1] !== 8'd0) begin n_fail++; $display("FAIL clr_count got=%0d exp=0", out_count[1]); end
        n_cmp++; if (out_sum[1] !== 8'h00) begin n_fail++; $display("FAIL clr_sum got=%h exp=00", rev8(out_sum[1])); end
        for (int i = 0; i < 4; i++) send(1, 8'h01);
        @(negedge clk);
        n_cmp++; if (out_sum[1] !== rev8(8'h04)) begin n_fail++; $display("FAIL clr_fresh_sum got=%h exp=04", rev8(out_sum[1])); end
        n_cmp++; if (out_carry[1] !== 1'b0) begin n_fail++; $display("FAIL clr_fresh_carry got=%b exp=0", out_carry[1]); end
        // clear while the total is held also drops it
        clear[1] = 1'b1;
        @(posedge clk);
        #1;
        clear[1] = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL clr_hold_valid got=%b exp=0", out_valid[1]); end
        n_cmp++; if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL clr_hold_ready got=%b exp=1", in_ready[1]); end
    endtask

    task automatic test_async_reset;
        send(1, 8'h05);
        send(1, 8'h06);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_count[1] !== 8'd0) begin n_fail++; $display("FAIL arst_count got=%0d exp=0", out_count[1]); end
        n_cmp++; if (out_sum[1] !== 8'h00) begin n_fail++; $display("FAIL arst_sum got=%h exp=00", rev8(out_sum[1])); end
        n_cmp++; if (out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", out_valid[1]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got=%b exp=1", in_ready[1]); end
        for (int i = 0; i < 4; i++) send(1, 8'h07);
        @(negedge clk);
        n_cmp++; if (out_sum[1] !== rev8(8'h1C)) begin n_fail++; $display("FAIL arst_next_sum got=%h exp=1c", rev8(out_sum[1])); end
        n_cmp++; if (out_valid[1] !== 1'b1) begin n_fail++; $display("FAIL arst_next_valid got=%b exp=1", out_valid[1]); end
        handshake(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            clear[i]     = 1'b0;
            in_valid[i]  = 1'b0;
            in_data[i]   = 8'h00;
            out_ready[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_carry();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
